rx_frame_fifo: RTL and testbench
================================

RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 Parameter ADDR_W, default 11, log2 of buffer depth in bytes (2048 entries).
REQ-002 Parameter CNT_W, default 16, width of the frame statistics counters.
REQ-003 clk_i  input  1  single clock for the whole block.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 rx_axis_mac_tdata_i  input  8  byte from the MAC receive stream.
REQ-006 rx_axis_mac_tvalid_i  input  1  byte valid; MAC cannot be stalled (no tready).
REQ-007 rx_axis_mac_tlast_i  input  1  last byte of frame.
REQ-008 rx_axis_mac_tuser_i  input  1  frame error flag, sampled with tlast.
REQ-009 rx_axis_tdata_o  output  8  byte to the frame consumer.
REQ-010 rx_axis_tvalid_o  output  1  output byte valid.
REQ-011 rx_axis_tlast_o  output  1  last byte of a forwarded frame.
REQ-012 rx_axis_tready_i  input  1  consumer accepts the byte.
REQ-013 ok_count_o  output  CNT_W  frames committed.
REQ-014 drop_count_o  output  CNT_W  frames discarded.

Function
REQ-015 The block SHALL be store-and-forward: no byte of a frame appears at the output before the frame's tlast is accepted with tuser=0.
REQ-016 Storage SHALL be 2^ADDR_W entries of 9 bits {tlast, tdata}, addressed by wr_ptr, commit_ptr and rd_ptr, each ADDR_W+1 bits wide and wrapping modulo 2^(ADDR_W+1).
REQ-017 The buffer is full when wr_ptr - rd_ptr == 2^ADDR_W; it is empty for reading when rd_ptr == commit_ptr.
REQ-018 Write FSM states SHALL be W_IDLE, W_STORE and W_DROP.
REQ-019 W_IDLE: on a valid byte, the byte SHALL be written if not full; the FSM goes to W_STORE, or to W_DROP if full; a byte with tlast completes the frame in the same cycle.
REQ-020 W_STORE: each valid byte SHALL be written and wr_ptr incremented.
REQ-021 W_STORE: writing into a full buffer SHALL reset wr_ptr to commit_ptr and enter W_DROP.
REQ-022 Frame end, tuser=0, not overflowed: commit_ptr SHALL be set to the post-increment wr_ptr, ok_count_o incremented, and the FSM returns to W_IDLE.
REQ-023 Frame end, tuser=1: wr_ptr SHALL be reset to commit_ptr, drop_count_o incremented, and the FSM returns to W_IDLE.
REQ-024 W_DROP: bytes SHALL be discarded; on tlast, drop_count_o is incremented and the FSM returns to W_IDLE.
REQ-025 Counters SHALL saturate at all-ones.
REQ-026 Read side: synchronous RAM read feeding an output register; tdata, tvalid and tlast SHALL hold stable while tvalid_o=1 and tready_i=0.
REQ-027 The output SHALL sustain one byte per cycle while tready_i=1 and committed data remains.
REQ-028 Latency: the first byte of a committed frame SHALL reach tvalid_o=1 no later than 3 cycles after the cycle its tlast was accepted, when the output is idle.
REQ-029 Reading a committed frame while a later frame is being written or rolled back SHALL be unaffected.
REQ-030 Rollback SHALL never move wr_ptr below commit_ptr.
REQ-031 A 1-byte frame SHALL be handled as any other frame.

Reset
REQ-032 Reset SHALL clear: all pointers; the FSM (to W_IDLE); the counters; rx_axis_tvalid_o; rx_axis_tlast_o; rx_axis_tdata_o (to 0).
REQ-033 Reset mid-frame SHALL discard all buffered and partial frames without counting them.
REQ-034 RAM contents need no reset.

Structure
REQ-035 rx_wr_state_t (W_IDLE, W_STORE, W_DROP) SHALL be declared in config_pkg.
REQ-036 The 9-bit entry width SHALL be a config_pkg constant.
REQ-037 Storage SHALL be a sub-module rx_fifo_ram: simple dual-port, 1-cycle read, no reset.

Verification
REQ-038 Good frame, 64 bytes 0x00..0x3F, tuser=0, tready=1 -> output 64 bytes in order, tlast on 0x3F only; ok_count_o=1.
REQ-039 Frame with tuser=1 on tlast, then good 10-byte frame -> only the 10-byte frame is output; drop_count_o=1; ok_count_o=1.
REQ-040 ADDR_W=4, 20-byte frame -> nothing output; drop_count_o=1; a following 8-byte frame passes intact.
REQ-041 tready toggled 1/0 every cycle during a 16-byte frame -> no byte lost or duplicated; outputs stable while stalled.
REQ-042 Second frame written while the first drains with tready=1 -> both frames output back-to-back, one byte per cycle.
REQ-043 rst_ni asserted mid-write of a frame, then released -> no output; counters 0; the next frame passes normally.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types and constants for the receive frame FIFO.
package config_pkg;

  localparam int ENTRY_W = 9;  // {tlast, tdata}

  typedef enum logic [1:0] {
    W_IDLE,
    W_STORE,
    W_DROP
  } rx_wr_state_t;

endpackage

// File: rtl/rx_fifo_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
module rx_fifo_ram
  import config_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem [2**ADDR_W];

  // Read data holds while re_i is low so a stalled consumer loses nothing.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive FIFO: buffers whole MAC frames, forwards only
// frames that ended without error and fit in the buffer.
module rx_frame_fifo
  import config_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       rx_axis_mac_tdata_i,
  input  logic             rx_axis_mac_tvalid_i,
  input  logic             rx_axis_mac_tlast_i,
  input  logic             rx_axis_mac_tuser_i,
  output logic [7:0]       rx_axis_tdata_o,
  output logic             rx_axis_tvalid_o,
  output logic             rx_axis_tlast_o,
  input  logic             rx_axis_tready_i,
  output logic [CNT_W-1:0] ok_count_o,
  output logic [CNT_W-1:0] drop_count_o
);

  localparam logic [ADDR_W:0]  PTR_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  rx_wr_state_t       state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q;
  logic [CNT_W-1:0]   ok_cnt_q, drop_cnt_q;
  logic               ok_inc, drop_inc, ram_we;
  logic               full, empty;
  logic               rd_en, vld_p1, load_out;
  logic [ENTRY_W-1:0] rd_data_p1;

  assign full  = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
  assign empty = (rd_ptr_q == commit_ptr_q);

  // Write FSM: bytes land past commit_ptr and only become readable on a
  // clean tlast; any failure rolls wr_ptr back to commit_ptr.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ok_inc       = 1'b0;
    drop_inc     = 1'b0;
    ram_we       = 1'b0;
    if (rx_axis_mac_tvalid_i) begin
      case (state_q)
        W_IDLE, W_STORE: begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            if (rx_axis_mac_tlast_i) begin
              drop_inc = 1'b1;
              state_d  = W_IDLE;
            end else begin
              state_d = W_DROP;
            end
          end else begin
            ram_we = 1'b1;
            if (!rx_axis_mac_tlast_i) begin
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              state_d  = W_STORE;
            end else if (rx_axis_mac_tuser_i) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = 1'b1;
              state_d  = W_IDLE;
            end else begin
              wr_ptr_d     = wr_ptr_q + PTR_ONE;
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              ok_inc       = 1'b1;
              state_d      = W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (rx_axis_mac_tlast_i) begin
            drop_inc = 1'b1;
            state_d  = W_IDLE;
          end
        end
        default: state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      ok_cnt_q     <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      if (ok_inc)   ok_cnt_q   <= sat_inc(ok_cnt_q);
      if (drop_inc) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  rx_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({rx_axis_mac_tlast_i, rx_axis_mac_tdata_i}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data_p1)
  );

  // Stage p1: RAM output register; a new read is issued only when p1 will
  // be vacated this cycle, so the RAM output doubles as the skid slot.
  assign load_out = vld_p1 && (!rx_axis_tvalid_o || rx_axis_tready_i);
  assign rd_en    = !empty && (!vld_p1 || load_out);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (!vld_p1 || load_out) vld_p1 <= rd_en;
    end
  end

  // Stage p2: output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_axis_tvalid_o <= 1'b0;
      rx_axis_tlast_o  <= 1'b0;
      rx_axis_tdata_o  <= '0;
    end else if (load_out) begin
      rx_axis_tvalid_o <= 1'b1;
      {rx_axis_tlast_o, rx_axis_tdata_o} <= rd_data_p1;
    end else if (rx_axis_tready_i) begin
      rx_axis_tvalid_o <= 1'b0;
    end
  end

  assign ok_count_o   = ok_cnt_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Scoreboard bench: a full-size instance and a 16-entry instance share the
// MAC stream; a select bit routes tvalid to one of them.
module tb_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vld, last, user, sel;
  logic        tready = 1'b1;
  logic        tog_en = 1'b0;
  logic        vld_b, vld_s;
  logic [7:0]  b_data, s_data;
  logic        b_vld, b_last, s_vld, s_last;
  logic [15:0] b_ok, b_drop, s_ok, s_drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_drive_cyc = 0;
  logic [8:0] q_b[$];
  logic [8:0] q_s[$];
  int acc_q[$];
  int rise_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    tready = tog_en ? ~tready : 1'b1;
  end

  assign vld_b = vld & sel;
  assign vld_s = vld & ~sel;

  rx_frame_fifo #(.ADDR_W(11), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_axis_mac_tdata_i(din), .rx_axis_mac_tvalid_i(vld_b),
    .rx_axis_mac_tlast_i(last), .rx_axis_mac_tuser_i(user),
    .rx_axis_tdata_o(b_data), .rx_axis_tvalid_o(b_vld),
    .rx_axis_tlast_o(b_last), .rx_axis_tready_i(tready),
    .ok_count_o(b_ok), .drop_count_o(b_drop)
  );

  rx_frame_fifo #(.ADDR_W(4), .CNT_W(16)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_axis_mac_tdata_i(din), .rx_axis_mac_tvalid_i(vld_s),
    .rx_axis_mac_tlast_i(last), .rx_axis_mac_tuser_i(user),
    .rx_axis_tdata_o(s_data), .rx_axis_tvalid_o(s_vld),
    .rx_axis_tlast_o(s_last), .rx_axis_tready_i(tready),
    .ok_count_o(s_ok), .drop_count_o(s_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the full-size instance.
  logic       b_stall = 1'b0;
  logic [8:0] b_hold;
  logic       b_prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_stall) chk("big_stall_hold", {b_vld, b_last, b_data}, {1'b1, b_hold});
      if (b_vld && tready) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL big_unexpected: got %0h expected no byte", {b_last, b_data});
        end else begin
          chk("big_data", {b_last, b_data}, q_b.pop_front());
        end
        acc_q.push_back(cyc);
      end
      if (b_vld && !b_prev_vld) rise_q.push_back(cyc);
      b_stall    = b_vld && !tready;
      b_hold     = {b_last, b_data};
      b_prev_vld = b_vld;
    end else begin
      b_stall    = 1'b0;
      b_prev_vld = 1'b0;
    end
  end

  // Monitor for the 16-entry instance.
  always @(negedge clk) begin
    if (rst_n && s_vld && tready) begin
      if (q_s.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL small_unexpected: got %0h expected no byte", {s_last, s_data});
      end else begin
        chk("small_data", {s_last, s_data}, q_s.pop_front());
      end
    end
  end

  task automatic send_frame(input int len, input logic [7:0] base, input bit err,
                            input bit big, input bit pass);
    if (pass) begin
      for (int i = 0; i < len; i++) begin
        if (big) q_b.push_back({(i == len - 1), 8'(base + 8'(i))});
        else     q_s.push_back({(i == len - 1), 8'(base + 8'(i))});
      end
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      sel  = big;
      vld  = 1'b1;
      din  = 8'(base + 8'(i));
      last = (i == len - 1);
      user = err && (i == len - 1);
      last_drive_cyc = cyc;
    end
    @(posedge clk); #1;
    vld = 1'b0; last = 1'b0; user = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_b.size() != 0 || q_s.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(q_b.size() + q_s.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; din = '0; last = 1'b0; user = 1'b0; sel = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", b_vld, 0);
    chk("rst_tlast", b_last, 0);
    chk("rst_tdata", b_data, 0);
    chk("rst_ok", b_ok, 0);
    chk("rst_drop", b_drop, 0);
    chk("rst_small_tvalid", s_vld, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 64-byte good frame, with store-and-forward and latency checks
    rise_q.delete();
    send_frame(64, 8'h00, 1'b0, 1'b1, 1'b1);
    drain("t1_drain");
    chk("t1_rise_seen", 64'(rise_q.size() > 0), 1);
    if (rise_q.size() > 0) begin
      chk("t1_store_fwd", 64'(rise_q[0] > last_drive_cyc), 1);
      chk("t1_latency_le3", 64'(rise_q[0] - last_drive_cyc <= 3), 1);
    end
    chk("t1_ok", b_ok, 1);
    chk("t1_drop", b_drop, 0);

    // errored frame dropped, following 10-byte frame forwarded
    send_frame(12, 8'h80, 1'b1, 1'b1, 1'b0);
    send_frame(10, 8'h40, 1'b0, 1'b1, 1'b1);
    drain("t2_drain");
    chk("t2_ok", b_ok, 2);
    chk("t2_drop", b_drop, 1);

    // overflow on the 16-entry instance, then an 8-byte frame fits
    send_frame(20, 8'h10, 1'b0, 1'b0, 1'b0);
    send_frame(8, 8'hA0, 1'b0, 1'b0, 1'b1);
    drain("t3_drain");
    chk("t3_small_drop", s_drop, 1);
    chk("t3_small_ok", s_ok, 1);
    chk("t3_big_ok", b_ok, 2);

    // tready toggling every cycle
    tog_en = 1'b1;
    send_frame(16, 8'h20, 1'b0, 1'b1, 1'b1);
    drain("t4_drain");
    tog_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t4_ok", b_ok, 3);

    // second frame written while the first drains: continuous output
    acc_q.delete();
    send_frame(32, 8'h50, 1'b0, 1'b1, 1'b1);
    send_frame(16, 8'hC0, 1'b0, 1'b1, 1'b1);
    drain("t5_drain");
    chk("t5_acc_count", 64'(acc_q.size()), 48);
    if (acc_q.size() > 0) chk("t5_b2b_span", 64'(acc_q[$] - acc_q[0]), 47);
    chk("t5_ok", b_ok, 5);

    // reset in the middle of a frame
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sel = 1'b1; vld = 1'b1; din = 8'(8'hE0 + 8'(i)); last = 1'b0; user = 1'b0;
    end
    rst_n = 1'b0;
    vld = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t6_rst_ok", b_ok, 0);
    chk("t6_rst_drop", b_drop, 0);
    chk("t6_rst_tvalid", b_vld, 0);
    chk("t6_rst_small_ok", s_ok, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t6_no_output", b_vld, 0);
    send_frame(6, 8'h70, 1'b0, 1'b1, 1'b1);
    drain("t6_drain");
    chk("t6_ok", b_ok, 1);
    chk("t6_drop", b_drop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
